// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [1:0] RK_BRANCH = 2'b00;
  localparam logic [1:0] RK_JUMP   = 2'b01;
  localparam logic [1:0] RK_JR     = 2'b10;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_target_gen.sv
// Combinational redirect-target calculation for branch, jump and jump-register.
module fetch_target_gen
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      redir_kind,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_imm,
  input  logic [25:0]     redir_index,
  input  logic [XLEN-1:0] redir_reg,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    target   = redir_base + (redir_imm << 2);
    misalign = 1'b0;
    case (redir_kind)
      RK_JUMP: target = {redir_base[XLEN-1:28], redir_index, 2'b00};
      RK_JR: begin
        // The low bits are forced to zero; the fault is only reported, not trapped.
        target   = {redir_reg[XLEN-1:2], 2'b00};
        misalign = |redir_reg[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding request FSM, IF/ID register
// and redirect/flush handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc_plus4,
  input  logic            redir_valid,
  input  logic [1:0]      redir_kind,
  input  logic [XLEN-1:0] redir_base,
  input  logic [XLEN-1:0] redir_imm,
  input  logic [25:0]     redir_index,
  input  logic [XLEN-1:0] redir_reg,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] target;
  logic            misalign;
  logic            redir_fire;
  logic [XLEN-1:0] pc_next;

  fetch_target_gen #(.XLEN(XLEN)) u_target_gen (
    .redir_kind  (redir_kind),
    .redir_base  (redir_base),
    .redir_imm   (redir_imm),
    .redir_index (redir_index),
    .redir_reg   (redir_reg),
    .target      (target),
    .misalign    (misalign)
  );

  assign redir_fire   = redir_valid && (redir_kind != 2'b11);
  assign misalign_err = redir_valid && misalign;
  assign pc_next      = pc_q + XLEN'(INSTR_BYTES);

  assign imem_addr   = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    imem_req = 1'b0;

    if (redir_fire) begin
      // A response still in flight must be swallowed before fetching the target.
      pc_d    = target;
      valid_d = 1'b0;
      state_d = (state_q != FETCH && !imem_rvalid) ? DROP : FETCH;
    end else begin
      if (valid_q && id_ready) valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          imem_req = !valid_q || id_ready;
          if (imem_req) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            pc4_d   = pc_next;
            valid_d = 1'b1;
            pc_d    = pc_next;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory responder,
// transaction-level model with per-cycle compare, and directed scenarios.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_base;
  logic [31:0] redir_imm;
  logic [25:0] redir_index;
  logic [31:0] redir_reg;
  logic        misalign_err;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .redir_valid  (redir_valid),
    .redir_kind   (redir_kind),
    .redir_base   (redir_base),
    .redir_imm    (redir_imm),
    .redir_index  (redir_index),
    .redir_reg    (redir_reg),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  int mis_cnt = 0;

  logic [31:0] rq_addr[$];
  int          rq_cyc[$];
  logic [31:0] acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] base,
                                               input logic [31:0] imm, input logic [25:0] idx,
                                               input logic [31:0] r);
    case (k)
      2'b00:   return base + imm * 4;
      2'b01:   return (base & 32'hF000_0000) | ({6'b0, idx} * 4);
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: answers each accepted request exactly lat cycles later.
  initial begin
    logic [31:0] paddr;
    int          cnt;
    logic        pend;
    pend        = 1'b0;
    cnt         = 0;
    paddr       = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) pend = 1'b0;
      else if (imem_req) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (reset) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
    end
  end

  // Model: next fetch address, one outstanding request (possibly wrong-path), IF/ID contents.
  initial begin
    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    logic        m_out, m_drop, m_valid, fire, exp_req, exp_mis;
    m_pc = RESET_PC; m_addr = '0; m_instr = '0; m_pc4 = '0;
    m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 0);
        check("rst_id_pc_plus4", id_pc_plus4, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_imem_req", imem_req, 1);
        check("rst_imem_addr", imem_addr, RESET_PC);
        m_pc = RESET_PC; m_instr = '0; m_pc4 = '0;
        m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
      end else begin
        fire    = redir_valid && (redir_kind != 2'b11);
        exp_req = !m_out && !fire && (!m_valid || id_ready);
        exp_mis = fire && (redir_kind == 2'b10) && (redir_reg[1:0] != 2'b00);
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("id_valid", id_valid, m_valid);
        if (m_valid) begin
          check("id_instr", id_instr, m_instr);
          check("id_pc_plus4", id_pc_plus4, m_pc4);
        end
        check("misalign_err", misalign_err, exp_mis);
        if (misalign_err) mis_cnt++;
        if (imem_req) begin
          rq_addr.push_back(imem_addr);
          rq_cyc.push_back(cyc);
        end
        if (id_valid && id_ready) acc_q.push_back(id_pc_plus4);

        if (fire) begin
          m_pc    = model_target(redir_kind, redir_base, redir_imm, redir_index, redir_reg);
          m_valid = 1'b0;
          if (m_out && !imem_rvalid) m_drop = 1'b1;
          else begin
            m_out  = 1'b0;
            m_drop = 1'b0;
          end
        end else begin
          if (m_valid && id_ready) m_valid = 1'b0;
          if (m_out && imem_rvalid) begin
            if (!m_drop) begin
              m_valid = 1'b1;
              m_instr = imem_rdata;
              m_pc4   = m_addr + 4;
              m_pc    = m_addr + 4;
            end
            m_out  = 1'b0;
            m_drop = 1'b0;
          end
          if (exp_req) begin
            m_out  = 1'b1;
            m_addr = m_pc;
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic flush_logs();
    rq_addr.delete();
    rq_cyc.delete();
    acc_q.delete();
  endtask

  task automatic next_req(input string name, output logic [31:0] a, output int c);
    int n = 0;
    while (rq_addr.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    if (rq_addr.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no imem_req within 100 cycles", name);
      a = 'x;
      c = -1000;
    end else begin
      a = rq_addr.pop_front();
      c = rq_cyc.pop_front();
    end
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] base, input logic [31:0] imm,
                          input logic [25:0] idx, input logic [31:0] r);
    redir_valid = 1'b1;
    redir_kind  = k;
    redir_base  = base;
    redir_imm   = imm;
    redir_index = idx;
    redir_reg   = r;
    tick();
    redir_valid = 1'b0;
  endtask

  task automatic do_reset(input int new_lat, input logic ready);
    reset = 1'b1;
    tick(2);
    lat      = new_lat;
    id_ready = ready;
    flush_logs();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a, a2;
    int          c, c0, c1, r, m0, n;
    reset = 1'b1; id_ready = 1'b1;
    redir_valid = 1'b0; redir_kind = 2'b00; redir_base = '0; redir_imm = '0;
    redir_index = '0; redir_reg = '0;
    tick(3);

    // Back-to-back fetch with L=1.
    do_reset(1, 1'b1);
    next_req("seq_req0", a, c0);
    check("seq_addr0", a, 32'h0);
    next_req("seq_req1", a, c1);
    check("seq_addr1", a, 32'h4);
    check("seq_gap01", 32'(c1 - c0), 2);
    next_req("seq_req2", a, c);
    check("seq_addr2", a, 32'h8);
    check("seq_gap12", 32'(c - c1), 2);
    n = 0;
    while (acc_q.size() < 3 && n < 50) begin tick(); n++; end
    check("seq_acc_count", 32'(acc_q.size() >= 3), 1);
    if (acc_q.size() >= 3) begin
      check("seq_pc4_0", acc_q[0], 32'h4);
      check("seq_pc4_1", acc_q[1], 32'h8);
      check("seq_pc4_2", acc_q[2], 32'hC);
    end

    // Backpressure: decode stalls after the first instruction.
    do_reset(1, 1'b0);
    n = 0;
    while (!id_valid && n < 50) begin tick(); n++; end
    check("bp_valid", id_valid, 1);
    tick(5);
    check("bp_instr_held", id_instr, mem_word(32'h0));
    check("bp_pc4_held", id_pc_plus4, 32'h4);
    check("bp_req_count", rq_addr.size(), 1);
    flush_logs();
    id_ready = 1'b1;
    next_req("bp_release", a, c);
    check("bp_next_addr", a, 32'h4);

    // Branch while a slow request is outstanding.
    lat = 3;
    tick(8);
    flush_logs();
    next_req("br_pre", a, c);
    r = cyc;
    redirect(2'b00, 32'h100, 32'hFFFF_FFFE, '0, '0);
    next_req("br_tgt", a, c);
    check("br_addr", a, 32'hF8);
    check("br_latency", 32'(c - r), 3);

    // Jump coincident with the response (L=1).
    lat = 1;
    tick(8);
    flush_logs();
    next_req("j_pre", a, c);
    check("j_rvalid_now", imem_rvalid, 1);
    r = cyc;
    redirect(2'b01, 32'h4000_0010, '0, 26'h000_0123, '0);
    next_req("j_tgt", a, c);
    check("j_addr", a, 32'h4000_048C);
    check("j_latency", 32'(c - r), 1);

    // Misaligned jr while waiting (L=2), then an ignored kind-11 redirect.
    lat = 2;
    tick(6);
    flush_logs();
    next_req("jr_pre", a, c);
    m0 = mis_cnt;
    r  = cyc;
    redirect(2'b10, '0, '0, '0, 32'h2003);
    next_req("jr_tgt", a, c);
    check("jr_addr", a, 32'h2000);
    check("jr_latency", 32'(c - r), 2);
    check("jr_misalign_pulses", mis_cnt - m0, 1);
    redirect(2'b11, 32'h500, 32'h7, 26'h3FF, 32'h8001);
    next_req("k11_next", a, c);
    check("k11_addr", a, 32'h2004);
    check("k11_no_misalign", mis_cnt - m0, 1);

    // PC wrap at the top of the address space.
    lat = 1;
    tick(6);
    flush_logs();
    next_req("wrap_pre", a, c);
    redirect(2'b10, '0, '0, '0, 32'hFFFF_FFFC);
    next_req("wrap_top", a, c);
    next_req("wrap_zero", a2, c);
    check("wrap_addr_top", a, 32'hFFFF_FFFC);
    check("wrap_addr_zero", a2, 32'h0);

    // Reset asserted while a request is outstanding.
    lat = 3;
    tick(8);
    flush_logs();
    next_req("rw_pre", a, c);
    reset = 1'b1;
    #1;
    check("rw_id_valid", id_valid, 0);
    check("rw_id_instr", id_instr, 0);
    check("rw_id_pc_plus4", id_pc_plus4, 0);
    check("rw_imem_addr", imem_addr, RESET_PC);
    tick(2);
    flush_logs();
    reset = 1'b0;
    r = cyc;
    next_req("rw_restart", a, c);
    check("rw_restart_addr", a, RESET_PC);
    check("rw_restart_cycle", 32'(c - r), 0);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
